alu_op_sequencer: RTL and testbench

- Issues one decoded ALU operation at a time to the execute datapath.
- Takes the 16-bit instruction and the 7-bit one-hot ALU class select from the ALU control decoder.
- Single-cycle classes get one execute step. Iterative shift classes get one step per shift position.
- Stalls fetch/decode while busy and returns completion to writeback over a valid/ready handshake.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_seq_step_cnt.sv | 32 +++
 rtl/alu_op_sequencer.sv | 114 +++++++++++
 tb/tb_alu_op_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned SEL_W     = 7;
    localparam int unsigned SHAMT_W   = 4;
    localparam int unsigned SHAMT_LSB = 0;

    // Bit positions within the one-hot ALU class select
    localparam int unsigned SEL_GEN = 0;
    localparam int unsigned SEL_SHL = 5;
    localparam int unsigned SEL_SHR = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    // Iterative shift classes run one execute step per shift position
    function automatic logic is_shift(input logic [SEL_W-1:0] sel);
        return sel[SEL_SHL] | sel[SEL_SHR];
    endfunction

    // True when more than one class bit is set
    function automatic logic is_multi_hot(input logic [SEL_W-1:0] sel);
        return (sel & (sel - SEL_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Decoder -> sequencer -> execute/writeback signal bundle.
// master: the sequencer side; slave: the surrounding pipeline.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [SEL_W-1:0]   in_sel;
    logic               step_en;
    logic               first_step;
    logic [SEL_W-1:0]   step_sel;
    logic               stall;
    logic               done_valid;
    logic               done_ready;
    logic [SEL_W-1:0]   done_sel;
    logic               done_err;

    modport master (
        input  in_valid, in_instr, in_sel, done_ready,
        output in_ready, step_en, first_step, step_sel, stall,
               done_valid, done_sel, done_err
    );

    modport slave (
        output in_valid, in_instr, in_sel, done_ready,
        input  in_ready, step_en, first_step, step_sel, stall,
               done_valid, done_sel, done_err
    );

endinterface

// File: rtl/alu_seq_step_cnt.sv
// Execute-step counter: loads a step count, decrements once per step and
// flags the last step. Never decrements below 1, so it cannot wrap.
module alu_seq_step_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] cnt_q;

    // Load on accept, count down while stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q > W'(1))) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt  = cnt_q;
    // A count of 0 (shift by zero) is a single pass-through step
    assign last = (cnt_q <= W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one decoded ALU operation at a time to the execute datapath and
// reports completion to writeback over a valid/ready handshake.
// Optional: define ALU_SEQ_ONEHOT_CHK_EN to reject multi-hot class selects
// (completes immediately with done_err=1 and done_sel=0).
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input logic                clk,
    input logic                rst,
    alu_op_sequencer_if.master bus
);

    seq_state_e         state_q;
    logic [SEL_W-1:0]   sel_q;
    logic               first_q;
    logic               accept;
    logic               exec;
    logic               resp;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] load_val;
    logic [SHAMT_W-1:0] cnt;
    logic               cnt_last;
`ifdef ALU_SEQ_ONEHOT_CHK_EN
    logic               err_q;
`endif

    // Only the shift-amount field of the instruction matters here
    logic unused_instr;
    assign unused_instr = ^bus.in_instr[INSTR_W-1:SHAMT_LSB+SHAMT_W];

    assign shamt    = bus.in_instr[SHAMT_LSB +: SHAMT_W];
    assign load_val = is_shift(bus.in_sel) ? shamt : SHAMT_W'(1);
    assign accept   = bus.in_valid & bus.in_ready;
    assign exec     = (state_q == EXEC) & ~rst;
    assign resp     = (state_q == RESP) & ~rst;

    alu_seq_step_cnt #(
        .W (SHAMT_W)
    ) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (load_val),
        .dec      (exec & ~cnt_last),
        .cnt      (cnt),
        .last     (cnt_last)
    );

    // Sequencer FSM: accept in IDLE, step in EXEC, hold completion in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            first_q <= 1'b0;
`ifdef ALU_SEQ_ONEHOT_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sel_q   <= bus.in_sel;
                        first_q <= 1'b1;
`ifdef ALU_SEQ_ONEHOT_CHK_EN
                        if (is_multi_hot(bus.in_sel)) begin
                            sel_q   <= '0;
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else
`endif
                        if (bus.in_sel == '0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    first_q <= 1'b0;
                    if (cnt_last) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    first_q <= 1'b0;
                    if (bus.done_ready) begin
                        state_q <= IDLE;
`ifdef ALU_SEQ_ONEHOT_CHK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE) & ~rst;
    assign bus.stall      = (state_q != IDLE) & ~rst;
    assign bus.step_en    = exec;
    assign bus.first_step = exec & first_q;
    // Shift by zero: one step with no class selected, operands pass through
    assign bus.step_sel   = (exec && (cnt != '0)) ? sel_q : '0;
    assign bus.done_valid = resp;
    assign bus.done_sel   = resp ? sel_q : '0;
`ifdef ALU_SEQ_ONEHOT_CHK_EN
    assign bus.done_err   = resp & err_q;
`else
    assign bus.done_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed vector table,
// hand-written reset/backpressure sequences and randomized ops checked
// against a closed-form expectation model.
module tb_alu_op_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         steps;
        logic [6:0] ssel;
        logic [6:0] dsel;
        logic       err;
    } exp_t;

    typedef struct {
        logic [6:0]  sel;
        logic [15:0] instr;
        int          bp;
        int          steps;
        logic [6:0]  ssel;
        logic [6:0]  dsel;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour of one op, straight from the class/shamt rules
    function automatic exp_t model(input logic [6:0] sel, input logic [15:0] instr);
        exp_t e;
        int   sh;
        sh     = int'(instr[3:0]);
        e.err  = 1'b0;
        e.dsel = sel;
        e.ssel = sel;
        if (sel == 7'd0) begin
            e.steps = 0;
        end
`ifdef ALU_SEQ_ONEHOT_CHK_EN
        else if ($countones(sel) > 1) begin
            e.steps = 0;
            e.err   = 1'b1;
            e.dsel  = 7'd0;
        end
`endif
        else if (sel[5] || sel[6]) begin
            e.steps = (sh == 0) ? 1 : sh;
            if (sh == 0) e.ssel = 7'd0;
        end else begin
            e.steps = 1;
        end
        return e;
    endfunction

    // Present one op from IDLE, follow it to completion, then handshake
    task automatic run_op(input logic [6:0] sel, input logic [15:0] instr, input int bp,
                          input int e_steps, input logic [6:0] e_ssel,
                          input logic [6:0] e_dsel, input logic e_err, input bit rnd_rdy);
        int steps;
        int cyc;
        bit got;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_instr = instr;
        chk("in_ready_idle", bus.in_ready, 1);
        chk("stall_idle", bus.stall, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sel   = 7'($urandom);
        bus.in_instr = 16'($urandom);
        steps = 0;
        cyc   = 1;
        got   = 1'b0;
        while (!got && cyc <= 40) begin
            chk("stall_busy", bus.stall, 1);
            if (bus.done_valid) begin
                got = 1'b1;
                chk("done_latency", cyc, e_steps + 1);
            end else begin
                if (bus.step_en) begin
                    chk("first_step", bus.first_step, (steps == 0) ? 1 : 0);
                    chk("step_sel", bus.step_sel, e_ssel);
                    steps++;
                end
                if (rnd_rdy) bus.done_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("step_count", steps, e_steps);
        bus.done_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_sel     = 7'b000_0001;
        for (int i = 0; i < bp; i++) begin
            chk("bp_done_valid", bus.done_valid, 1);
            chk("bp_done_sel", bus.done_sel, e_dsel);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_step_en", bus.step_en, 0);
            @(posedge clk); #1;
        end
        chk("done_valid", bus.done_valid, 1);
        chk("done_sel", bus.done_sel, e_dsel);
        chk("done_err", bus.done_err, e_err);
        bus.in_valid   = 1'b0;
        bus.done_ready = 1'b1;
        @(posedge clk); #1;
        bus.done_ready = 1'b0;
        chk("post_done_valid", bus.done_valid, 0);
        chk("post_stall", bus.stall, 0);
        chk("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [6:0]  sel;
        logic [15:0] instr;
        int          n;

        checks = 0;
        errors = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sel     = '0;
        bus.in_instr   = '0;
        bus.done_ready = 1'b0;

        vecs.push_back('{7'b000_0001, 16'h1234, 0, 1, 7'b000_0001, 7'b000_0001, 1'b0});
        vecs.push_back('{7'b010_0000, 16'h0005, 0, 5, 7'b010_0000, 7'b010_0000, 1'b0});
        vecs.push_back('{7'b100_0000, 16'hABC0, 0, 1, 7'b000_0000, 7'b100_0000, 1'b0});
        vecs.push_back('{7'b100_0000, 16'h000F, 1, 15, 7'b100_0000, 7'b100_0000, 1'b0});
        vecs.push_back('{7'b000_0100, 16'hFFFF, 4, 1, 7'b000_0100, 7'b000_0100, 1'b0});
        vecs.push_back('{7'b000_0000, 16'h00FF, 2, 0, 7'b000_0000, 7'b000_0000, 1'b0});
`ifdef ALU_SEQ_ONEHOT_CHK_EN
        vecs.push_back('{7'b000_0011, 16'h0007, 0, 0, 7'b000_0000, 7'b000_0000, 1'b1});
        vecs.push_back('{7'b010_0001, 16'h0003, 0, 0, 7'b000_0000, 7'b000_0000, 1'b1});
`else
        vecs.push_back('{7'b000_0011, 16'h0007, 0, 1, 7'b000_0011, 7'b000_0011, 1'b0});
        vecs.push_back('{7'b010_0001, 16'h0003, 0, 3, 7'b010_0001, 7'b010_0001, 1'b0});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_step_en", bus.step_en, 0);
        chk("rst_done_valid", bus.done_valid, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_done_sel", bus.done_sel, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].instr, vecs[i].bp, vecs[i].steps,
                   vecs[i].ssel, vecs[i].dsel, vecs[i].err, 1'b0);
        end

        // Reset during the 4th step of a shift by 9
        bus.in_valid = 1'b1;
        bus.in_sel   = 7'b100_0000;
        bus.in_instr = 16'h0009;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_step_en", bus.step_en, 1);
        chk("mid_first_step", bus.first_step, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_step_en", bus.step_en, 0);
        chk("mid_rst_stall", bus.stall, 0);
        chk("mid_rst_done_valid", bus.done_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("mid_rel_in_ready", bus.in_ready, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("mid_after_done_valid", bus.done_valid, 0);
            chk("mid_after_step_en", bus.step_en, 0);
        end

        // Randomized ops against the model
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0:       sel = 7'(1 << $urandom_range(0, 6));
                1:       sel = $urandom_range(0, 1) ? 7'b010_0000 : 7'b100_0000;
                2:       sel = 7'd0;
                default: sel = 7'($urandom);
            endcase
            instr = 16'($urandom);
            e = model(sel, instr);
            run_op(sel, instr, $urandom_range(0, 3), e.steps, e.ssel, e.dsel, e.err, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
